// File: rtl/vote_tally.sv
// Voting-machine tally: debounced one-vote-per-press counting with saturating
// per-candidate counters, running total, and registered leader/tie detection.
module vote_tally #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 mode,
  input  logic                                 clear,
  input  logic [NUM_CAND-1:0]                  vote_valid,
  output logic                                 vote_ack,
  output logic                                 vote_err,
  output logic [NUM_CAND*CNT_W-1:0]            cand_count,
  output logic [CNT_W+$clog2(NUM_CAND)-1:0]    total_votes,
  output logic [$clog2(NUM_CAND)-1:0]          leader,
  output logic                                 tie,
  output logic                                 busy
);

  localparam int unsigned IDX_W = $clog2(NUM_CAND);
  localparam int unsigned TOT_W = CNT_W + IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [NUM_CAND-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [TOT_W-1:0]               total_q, total_d;
  logic                           ack_q, ack_d;
  logic                           err_q, err_d;
  logic [IDX_W-1:0]               leader_q, lead_c;
  logic                           tie_q, tie_c;
  logic [IDX_W-1:0]               sel;
  logic [CNT_W-1:0]               max_c;

  // State and count registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      total_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      leader_q <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      total_q  <= total_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      leader_q <= lead_c;
      tie_q    <= tie_c;
    end
  end

  // Index of the pressed button; only meaningful when the press is one-hot
  always_comb begin
    sel = '0;
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      if (vote_valid[i]) sel = IDX_W'(i);
    end
  end

  // Next-state, press evaluation and clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|vote_valid) begin
          state_d = HOLD;
          if (!mode && $onehot(vote_valid) && (cnt_q[sel] != CNT_MAX)) begin
            cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
            total_d    = total_q + TOT_W'(1);
            ack_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (vote_valid == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over a simultaneous press; that press is already rejected since mode=1
    if (mode && clear) begin
      cnt_d   = '0;
      total_d = '0;
    end
  end

  // Leader is the lowest index holding the maximum; tie needs a nonzero shared max
  always_comb begin
    max_c  = '0;
    lead_c = '0;
    tie_c  = 1'b0;
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      if (cnt_q[i] > max_c) begin
        max_c  = cnt_q[i];
        lead_c = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      if ((cnt_q[i] == max_c) && (IDX_W'(i) != lead_c)) tie_c = 1'b1;
    end
    if (max_c == '0) tie_c = 1'b0;
  end

  assign cand_count  = cnt_q;
  assign total_votes = total_q;
  assign vote_ack    = ack_q;
  assign vote_err    = err_q;
  assign leader      = leader_q;
  assign tie         = tie_q;
  assign busy        = (state_q == HOLD);

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally (NUM_CAND=4, CNT_W=2 so saturation is reachable).
module tb_vote_tally;

  localparam int unsigned NC = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned IW = 2;

  logic                clock;
  logic                reset;
  logic                mode;
  logic                clear;
  logic [NC-1:0]       vote_valid;
  logic                vote_ack;
  logic                vote_err;
  logic [NC*CW-1:0]    cand_count;
  logic [CW+IW-1:0]    total_votes;
  logic [IW-1:0]       leader;
  logic                tie;
  logic                busy;

  int total;
  int bad;

  vote_tally #(.NUM_CAND(NC), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .clear       (clear),
    .vote_valid  (vote_valid),
    .vote_ack    (vote_ack),
    .vote_err    (vote_err),
    .cand_count  (cand_count),
    .total_votes (total_votes),
    .leader      (leader),
    .tie         (tie),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Press for one evaluation cycle, capture the pulses, then release
  task automatic press(input logic [NC-1:0] v, output logic a, output logic e);
    vote_valid = v;
    step();
    a = vote_ack;
    e = vote_err;
    vote_valid = '0;
    step();
  endtask

  task automatic test_reset();
    #1;
    total++; if (cand_count !== 8'h00) begin bad++; $display("FAIL reset_counts: got %h want 00", cand_count); end
    total++; if (total_votes !== 4'd0) begin bad++; $display("FAIL reset_total: got %0d want 0", total_votes); end
    total++; if ({vote_ack, vote_err, busy, tie} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {vote_ack, vote_err, busy, tie}); end
    total++; if (leader !== 2'd0) begin bad++; $display("FAIL reset_leader: got %0d want 0", leader); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_hold();
    do_reset();
    vote_valid = 4'b0001;
    step();
    total++; if ({vote_ack, vote_err} !== 2'b10) begin bad++; $display("FAIL hold_ack: got %b want 10", {vote_ack, vote_err}); end
    total++; if (cand_count !== 8'h01 || total_votes !== 4'd1) begin bad++; $display("FAIL hold_count: got %h/%0d want 01/1", cand_count, total_votes); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy: got %b want 1", busy); end
    for (int n = 0; n < 4; n++) begin
      step();
      total++; if ({vote_ack, vote_err, busy} !== 3'b001) begin bad++; $display("FAIL hold_no_repeat: got %b want 001", {vote_ack, vote_err, busy}); end
    end
    vote_valid = '0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_release: got %b want 0", busy); end
    total++; if (cand_count !== 8'h01 || leader !== 2'd0 || tie !== 1'b0) begin bad++; $display("FAIL hold_final: got %h %0d %b want 01 0 0", cand_count, leader, tie); end
  endtask

  task automatic test_multi_hot();
    logic a, e;
    do_reset();
    press(4'b0110, a, e);
    total++; if ({a, e} !== 2'b01) begin bad++; $display("FAIL multi_err: got %b want 01", {a, e}); end
    total++; if (cand_count !== 8'h00 || total_votes !== 4'd0) begin bad++; $display("FAIL multi_counts: got %h/%0d want 00/0", cand_count, total_votes); end
    vote_valid = 4'b0100;
    step();
    total++; if (vote_ack !== 1'b1 || cand_count !== 8'h10) begin bad++; $display("FAIL multi_next: got %b %h want 1 10", vote_ack, cand_count); end
    total++; if (leader !== 2'd0) begin bad++; $display("FAIL leader_latency: got %0d want 0", leader); end
    vote_valid = '0;
    step();
    total++; if (leader !== 2'd2 || tie !== 1'b0) begin bad++; $display("FAIL multi_leader: got %0d %b want 2 0", leader, tie); end
  endtask

  task automatic test_saturate();
    logic a, e, ea;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      press(4'b0010, a, e);
      ea = (n < 3);
      total++; if (a !== ea || e !== !ea) begin bad++; $display("FAIL sat_press%0d: got %b%b want %b%b", n, a, e, ea, !ea); end
    end
    total++; if (cand_count !== 8'h0C || total_votes !== 4'd3) begin bad++; $display("FAIL sat_counts: got %h/%0d want 0c/3", cand_count, total_votes); end
    total++; if (leader !== 2'd1 || tie !== 1'b0) begin bad++; $display("FAIL sat_leader: got %0d %b want 1 0", leader, tie); end
  endtask

  task automatic test_tie();
    logic a, e;
    do_reset();
    press(4'b0001, a, e);
    press(4'b0001, a, e);
    press(4'b1000, a, e);
    press(4'b1000, a, e);
    total++; if (leader !== 2'd0 || tie !== 1'b1) begin bad++; $display("FAIL tie_set: got %0d %b want 0 1", leader, tie); end
    press(4'b1000, a, e);
    total++; if (leader !== 2'd3 || tie !== 1'b0) begin bad++; $display("FAIL tie_break: got %0d %b want 3 0", leader, tie); end
    total++; if (cand_count !== 8'hC2 || total_votes !== 4'd5) begin bad++; $display("FAIL tie_counts: got %h/%0d want c2/5", cand_count, total_votes); end
  endtask

  task automatic test_readout_clear();
    logic a, e;
    mode = 1'b1;
    press(4'b0001, a, e);
    total++; if ({a, e} !== 2'b01 || cand_count !== 8'hC2) begin bad++; $display("FAIL readout_press: got %b %h want 01 c2", {a, e}, cand_count); end
    mode = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++; if (cand_count !== 8'hC2 || total_votes !== 4'd5) begin bad++; $display("FAIL clear_ignored: got %h/%0d want c2/5", cand_count, total_votes); end
    mode = 1'b1;
    clear = 1'b1;
    vote_valid = 4'b0010;
    step();
    total++; if ({vote_ack, vote_err} !== 2'b01) begin bad++; $display("FAIL clear_press_err: got %b want 01", {vote_ack, vote_err}); end
    total++; if (cand_count !== 8'h00 || total_votes !== 4'd0) begin bad++; $display("FAIL clear_counts: got %h/%0d want 00/0", cand_count, total_votes); end
    clear = 1'b0;
    vote_valid = '0;
    step();
    mode = 1'b0;
    total++; if (leader !== 2'd0 || tie !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL clear_leader: got %0d %b %b want 0 0 0", leader, tie, busy); end
  endtask

  task automatic test_hold_ignore();
    do_reset();
    vote_valid = 4'b0100;
    step();
    total++; if (vote_ack !== 1'b1) begin bad++; $display("FAIL ign_first: got %b want 1", vote_ack); end
    vote_valid = 4'b0110;
    step();
    total++; if ({vote_ack, vote_err, busy} !== 3'b001) begin bad++; $display("FAIL ign_added_bit: got %b want 001", {vote_ack, vote_err, busy}); end
    mode = 1'b1;
    step();
    total++; if ({vote_ack, vote_err, busy} !== 3'b001) begin bad++; $display("FAIL ign_mode_flip: got %b want 001", {vote_ack, vote_err, busy}); end
    vote_valid = '0;
    step();
    mode = 1'b0;
    total++; if (busy !== 1'b0 || cand_count !== 8'h10 || total_votes !== 4'd1) begin bad++; $display("FAIL ign_final: got %b %h %0d want 0 10 1", busy, cand_count, total_votes); end
  endtask

  task automatic test_reset_mid_hold();
    logic a, e;
    do_reset();
    press(4'b0001, a, e);
    vote_valid = 4'b1000;
    step();
    total++; if (vote_ack !== 1'b1 || cand_count !== 8'h41) begin bad++; $display("FAIL mid_setup: got %b %h want 1 41", vote_ack, cand_count); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (cand_count !== 8'h00 || total_votes !== 4'd0) begin bad++; $display("FAIL mid_async_counts: got %h/%0d want 00/0", cand_count, total_votes); end
    total++; if ({vote_ack, vote_err, busy, tie, leader} !== 6'b0) begin bad++; $display("FAIL mid_async_flags: got %b want 000000", {vote_ack, vote_err, busy, tie, leader}); end
    #1;
    reset = 1'b0;
    step();
    total++; if (vote_ack !== 1'b1 || cand_count !== 8'h40 || total_votes !== 4'd1) begin bad++; $display("FAIL mid_reeval: got %b %h %0d want 1 40 1", vote_ack, cand_count, total_votes); end
    vote_valid = '0;
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    mode = 1'b0;
    clear = 1'b0;
    vote_valid = '0;
    test_reset();
    test_single_hold();
    test_multi_hot();
    test_saturate();
    test_tie();
    test_readout_clear();
    test_hold_ignore();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vote_tally.md
VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 Parameter NUM_CAND, default 4, number of candidates (2..16).
REQ-002 Parameter CNT_W, default 8, width of each per-candidate counter (>=2).
REQ-003 Port clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-005 Port mode  input  1  0 = voting, 1 = result/readout.
REQ-006 Port clear  input  1  synchronous count clear; honoured only when mode=1.
REQ-007 Port vote_valid  input  NUM_CAND  bit i = candidate i button pressed (level, may be held many cycles).
REQ-008 Port vote_ack  output  1  one-cycle pulse: a vote was counted.
REQ-009 Port vote_err  output  1  one-cycle pulse: a press was rejected.
REQ-010 Port cand_count  output  NUM_CAND*CNT_W  flat bus; candidate i at bits [i*CNT_W +: CNT_W].
REQ-011 Port total_votes  output  CNT_W+clog2(NUM_CAND)  sum of all counted votes.
REQ-012 Port leader  output  clog2(NUM_CAND)  index of candidate with highest count.
REQ-013 Port tie  output  1  two or more candidates share the nonzero maximum.
REQ-014 Port busy  output  1  high while FSM is in HOLD.

Function
REQ-015 FSM states IDLE and HOLD; a press is evaluated only in IDLE; exactly one evaluation per press.
REQ-016 IDLE, vote_valid==0: remain IDLE, no pulse.
REQ-017 IDLE, vote_valid!=0: go to HOLD at next edge, and at that same edge evaluate the press per REQ-018..REQ-020.
REQ-018 Accept when mode=0, vote_valid exactly one-hot (bit k), cand_count[k] < 2^CNT_W-1: cand_count[k] +1, total_votes +1, vote_ack=1; all visible in the cycle after the sampling edge (latency 1).
REQ-019 Reject with vote_err=1 (counts unchanged) when vote_valid multi-hot, or mode=1, or cand_count[k]==2^CNT_W-1 (saturation; counters never wrap).
REQ-020 vote_ack and vote_err are mutually exclusive and each high for exactly one cycle per press.
REQ-021 HOLD: remain while vote_valid!=0; return to IDLE on the edge after vote_valid==0; bits added/changed during HOLD are ignored (no pulse).
REQ-022 A mode change while in HOLD does not alter the HOLD exit condition.
REQ-023 clear=1 with mode=1: all cand_count and total_votes become 0 at next edge; clear with mode=0 is ignored.
REQ-024 clear and a press in the same IDLE cycle (mode=1): clear takes effect, press rejected with vote_err.
REQ-025 leader/tie registered from current counts every cycle: latency 1 cycle after any count change.
REQ-026 leader = lowest index among candidates holding the maximum count.
REQ-027 All counts zero: leader=0, tie=0.
REQ-028 total_votes never overflows (width guarantees it); equals sum of cand_count at all times.

Reset
REQ-029 On reset assertion, asynchronously: state=IDLE, cand_count all 0, total_votes=0, vote_ack=0, vote_err=0, leader=0, tie=0, busy=0.
REQ-030 Reset asserted mid-HOLD or in the ack cycle: pulse aborted, no count change beyond reset; after release a still-held vote_valid is evaluated as a new press in IDLE.
REQ-031 First evaluation occurs on the first rising edge with reset low.

Verification
REQ-032 mode=0, vote_valid=0001 held 5 cycles then 0 -> one vote_ack, cand_count[0]=1, total_votes=1, busy high until release, leader=0, tie=0.
REQ-033 mode=0, vote_valid=0110 -> vote_err pulse, all counts 0; then 0100 press -> cand_count[2]=1, leader=2 one cycle later.
REQ-034 CNT_W=2, 4 presses on candidate 1 -> counts 1,2,3 acked, 4th vote_err, cand_count[1]=3, total_votes=3.
REQ-035 Candidates 0 and 3 each receive 2 votes -> leader=0, tie=1; one more vote for 3 -> leader=3, tie=0.
REQ-036 mode=1: press 0001 -> vote_err, no count; clear=1 -> all counts 0 next cycle; clear with mode=0 -> counts unchanged.
REQ-037 reset asserted between clock edges during HOLD with counts nonzero -> all outputs 0 immediately, before next edge.
